multi_timer: RTL and testbench

//  Memory-mapped bank of NCH independent interval timers on the processor data bus,

---
 rtl/multi_timer.sv | 110 +++++++++++
 tb/tb_multi_timer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Bank of NCH memory-mapped interval timers sharing one prescaler.
// Each channel has CNT/LIM/CTL registers with sticky READY/OVERRUN and an IRQ enable.
module multi_timer #(
    parameter int unsigned     BITS   = 32,
    parameter int unsigned     NCH    = 4,
    parameter logic [BITS-1:0] BASE   = 32'hFFFFF100,
    parameter int unsigned     STRIDE = 16,
    parameter int unsigned     PRESC  = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] addr,
    input  logic [BITS-1:0] wdata,
    input  logic            we,
    output logic [BITS-1:0] rdata,
    output logic            sel,
    output logic            irq
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;

    logic [BITS-1:0] cnt_q [NCH];
    logic [BITS-1:0] cnt_d [NCH];
    logic [BITS-1:0] lim_q [NCH];
    logic [BITS-1:0] lim_d [NCH];
    logic [NCH-1:0]  ready_q, ready_d;
    logic [NCH-1:0]  ovr_q, ovr_d;
    logic [NCH-1:0]  ie_q, ie_d;

    logic [NCH-1:0]  hit_cnt, hit_lim, hit_ctl;
    logic [NCH-1:0]  wr_cnt, wr_lim, wr_ctl;
    logic [NCH-1:0]  wrap;

    // With PRESC=1 the counter stays at 0 and tick is permanently high.
    assign tick    = (presc_q == PW'(PRESC - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            hit_cnt[c] = (addr == BASE + BITS'(c) * BITS'(STRIDE));
            hit_lim[c] = (addr == BASE + BITS'(c) * BITS'(STRIDE) + BITS'(4));
            hit_ctl[c] = (addr == BASE + BITS'(c) * BITS'(STRIDE) + BITS'(8));
            wr_cnt[c]  = we & hit_cnt[c];
            wr_lim[c]  = we & hit_lim[c];
            wr_ctl[c]  = we & hit_ctl[c];
            // A CNT or LIM write replaces the tick entirely, flags included.
            wrap[c]    = tick & ~wr_cnt[c] & ~wr_lim[c] & (lim_q[c] != '0) &
                         (cnt_q[c] == lim_q[c] - 1'b1);
        end
    end

    assign sel = |{hit_cnt, hit_lim, hit_ctl};
    assign irq = |(ready_q & ie_q);

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            cnt_d[c] = cnt_q[c];
            lim_d[c] = lim_q[c];
            if (wr_lim[c]) begin
                lim_d[c] = wdata;
                cnt_d[c] = '0;
            end else if (wr_cnt[c]) begin
                cnt_d[c] = wdata;
            end else if (wrap[c]) begin
                cnt_d[c] = '0;
            end else if (tick) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
            // Flag set from a same-cycle wrap wins over a clearing CTL write.
            ready_d[c] = (ready_q[c] & ~(wr_ctl[c] & ~wdata[0])) | (wrap[c] & ~ready_q[c]);
            ovr_d[c]   = (ovr_q[c] & ~(wr_ctl[c] & ~wdata[1])) | (wrap[c] & ready_q[c]);
            ie_d[c]    = wr_ctl[c] ? wdata[4] : ie_q[c];
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (hit_cnt[c]) rdata = cnt_q[c];
            if (hit_lim[c]) rdata = lim_q[c];
            if (hit_ctl[c]) rdata = BITS'({ie_q[c], 2'b00, ovr_q[c], ready_q[c]});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            ready_q <= '0;
            ovr_q   <= '0;
            ie_q    <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
                lim_q[c] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
                lim_q[c] <= lim_d[c];
            end
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer with PRESC=4, NCH=4, BITS=32.
// Expectations are queued as stimulus is applied and popped as the bus is read back.
module tb_multi_timer;

    localparam int unsigned NCH    = 4;
    localparam int unsigned STRIDE = 16;
    localparam logic [31:0] BASE   = 32'hFFFFF100;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        we    = 1'b0;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;

    typedef struct {
        string       name;
        int          kind;  // 0 rdata, 1 sel, 2 irq
        logic [31:0] addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pc;

    multi_timer #(
        .BITS  (32),
        .NCH   (NCH),
        .BASE  (BASE),
        .STRIDE(STRIDE),
        .PRESC (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .wdata(wdata),
        .we   (we),
        .rdata(rdata),
        .sel  (sel),
        .irq  (irq)
    );

    always #10 clk = ~clk;

    // Reference prescaler phase: a tick edge follows whenever pc==3.
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 0;
        else       pc <= (pc == 3) ? 0 : pc + 1;
    end

    function automatic logic [31:0] ra(int c, int off);
        return BASE + 32'(c * STRIDE + off);
    endfunction

    task automatic push(string n, int k, logic [31:0] a, logic [31:0] v);
        sb.push_back('{name: n, kind: k, addr: a, val: v});
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic to_tick;
        while (pc != 3) @(negedge clk);
    endtask

    task automatic test_reset;
        exp_t e; logic [31:0] got;
        repeat (2) @(negedge clk);
        for (int c = 0; c < NCH; c++)
            for (int o = 0; o < 12; o += 4)
                push($sformatf("reset_ch%0d_off%0d", c, o), 0, ra(c, o), 0);
        push("sel_valid", 1, ra(2, 4), 1);
        push("sel_gap", 1, BASE + 32'd12, 0);
        push("rdata_gap", 0, BASE + 32'd12, 0);
        push("sel_beyond", 1, ra(NCH, 0), 0);
        push("rdata_beyond", 0, ra(NCH, 0), 0);
        push("sel_below", 1, BASE - 32'd4, 0);
        push("irq_reset", 2, BASE, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap_irq;
        exp_t e; logic [31:0] got;
        to_tick;
        wr(ra(0, 4), 3);
        wr(ra(0, 8), 32'h10);
        for (int k = 1; k <= 12; k++) begin
            push($sformatf("ch0_cnt_k%0d", k), 0, ra(0, 0), 32'((k / 4) % 3));
            push($sformatf("ch0_irq_k%0d", k), 2, BASE, 32'(k >= 12));
            while (sb.size() > 0) begin
                e = sb.pop_front(); addr = e.addr; #1;
                got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
                end
            end
            if (k < 12) @(negedge clk);
        end
        push("ch0_ctl_ready", 0, ra(0, 8), 32'h11);
        push("ch0_sel", 1, ra(0, 8), 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        wr(ra(0, 8), 32'h10);
        push("ch0_irq_cleared", 2, BASE, 0);
        push("ch0_ctl_cleared", 0, ra(0, 8), 32'h10);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        wr(ra(0, 8), 0);
    endtask

    task automatic test_overrun;
        exp_t e; logic [31:0] got;
        to_tick;
        wr(ra(1, 4), 2);
        repeat (8) @(negedge clk);
        push("ch1_cnt_first_wrap", 0, ra(1, 0), 0);
        push("ch1_ctl_first_wrap", 0, ra(1, 8), 32'h1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        repeat (8) @(negedge clk);
        push("ch1_ctl_overrun", 0, ra(1, 8), 32'h3);
        push("ch1_irq_masked", 2, BASE, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        wr(ra(1, 8), 32'h2);
        push("ch1_ctl_clear_ready_only", 0, ra(1, 8), 32'h2);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_same_cycle;
        exp_t e; logic [31:0] got;
        to_tick;
        wr(ra(2, 4), 1);
        push("ch2_ctl_after_lim", 0, ra(2, 8), 0);
        push("ch2_cnt_after_lim", 0, ra(2, 0), 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        to_tick;
        wr(ra(2, 8), 0);
        push("ch2_set_wins", 0, ra(2, 8), 32'h1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        to_tick;
        wr(ra(2, 0), 7);
        push("ch2_cnt_write_wins", 0, ra(2, 0), 32'd7);
        push("ch2_flags_kept", 0, ra(2, 8), 32'h1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_lim_zero;
        exp_t e; logic [31:0] got;
        to_tick;
        @(negedge clk);
        wr(ra(3, 0), 32'hFFFF_FFFF);
        push("ch3_cnt_written", 0, ra(3, 0), 32'hFFFF_FFFF);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        to_tick;
        @(negedge clk);
        push("ch3_cnt_rollover", 0, ra(3, 0), 0);
        push("ch3_no_ready", 0, ra(3, 8), 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_reset_mid_count;
        exp_t e; logic [31:0] got;
        to_tick;
        @(negedge clk);
        wr(ra(0, 0), 2);
        wr(ra(0, 8), 32'h10);
        repeat (3) begin
            to_tick;
            @(negedge clk);
        end
        push("ch0_cnt_pre_reset", 0, ra(0, 0), 2);
        push("ch0_ctl_pre_reset", 0, ra(0, 8), 32'h11);
        push("irq_pre_reset", 2, BASE, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        #2 reset = 1'b1;
        #1;
        push("ch0_cnt_async_reset", 0, ra(0, 0), 0);
        push("ch0_ctl_async_reset", 0, ra(0, 8), 0);
        push("ch0_lim_async_reset", 0, ra(0, 4), 0);
        push("irq_async_reset", 2, BASE, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.addr; #1;
            got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            push($sformatf("first_tick_edge%0d", k), 0, ra(0, 0), 32'(k == 4));
            while (sb.size() > 0) begin
                e = sb.pop_front(); addr = e.addr; #1;
                got = (e.kind == 0) ? rdata : (e.kind == 1) ? 32'(sel) : 32'(irq);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%h, required 0x%h", e.name, got, e.val);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_wrap_irq;
        test_overrun;
        test_same_cycle;
        test_lim_zero;
        test_reset_mid_count;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
